// File: rtl/clkfx_lock_sequencer.sv
// Lock-window reset sequencer and divide-by-DIV clock-enable generator for the DCM CLKFX domain.
// Optional build macro CLKFX_LOCK_GLITCH_FILTER_EN: RUN ignores lock dropouts shorter than 3 cycles.
module clkfx_lock_sequencer #(
  parameter int DIV           = 5,
  parameter int STABLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked_in,
  output logic       sys_rst_n,
  output logic       lock_ok,
  output logic       ce_div,
  output logic [2:0] phase,
  output logic [1:0] state,
  output logic [7:0] relock_count
);

  localparam int             CW       = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [2:0]     PH_LAST  = 3'(DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    ILLEGAL   = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    phase_reg, phase_next;
  logic [7:0]    relock_reg, relock_next;
  logic          s1_reg, s2_reg;
  logic          lk;
  logic          lost;

  assign lk = s2_reg;

`ifdef CLKFX_LOCK_GLITCH_FILTER_EN
  // Counts consecutive low cycles seen in RUN; the third one declares the lock lost.
  logic [1:0] low_reg, low_next;

  assign lost = !lk && (low_reg == 2'd2);

  always_comb begin
    low_next = 2'd0;
    if (state_reg == RUN && !lk && !lost)
      low_next = low_reg + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) low_reg <= 2'd0;
    else        low_reg <= low_next;
  end
`else
  assign lost = !lk;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      state_reg  <= WAIT_LOCK;
      cnt_reg    <= '0;
      phase_reg  <= 3'd0;
      relock_reg <= 8'd0;
    end else begin
      s1_reg     <= locked_in;
      s2_reg     <= s1_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      phase_reg  <= phase_next;
      relock_reg <= relock_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    phase_next  = phase_reg;
    relock_next = relock_reg;
    case (state_reg)
      WAIT_LOCK: begin
        cnt_next   = '0;
        phase_next = 3'd0;
        if (lk) state_next = STABILIZE;
      end
      STABILIZE: begin
        phase_next = 3'd0;
        if (!lk) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
        if (lost) begin
          state_next = WAIT_LOCK;
          phase_next = 3'd0;
          if (relock_reg != 8'hFF) relock_next = relock_reg + 8'd1;
        end else begin
          phase_next = (phase_reg == PH_LAST) ? 3'd0 : phase_reg + 3'd1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean restart.
        state_next = WAIT_LOCK;
        cnt_next   = '0;
        phase_next = 3'd0;
      end
    endcase
  end

  assign sys_rst_n    = (state_reg == RUN);
  assign lock_ok      = (state_reg == RUN);
  assign ce_div       = (state_reg == RUN) && (phase_reg == PH_LAST);
  assign phase        = phase_reg;
  assign state        = state_reg;
  assign relock_count = relock_reg;

endmodule

// File: tb/tb_clkfx_lock_sequencer.sv
// Directed bench: a 64-cycle-window instance driven from a vector table and a
// 2-cycle-window instance used for relock counting, mid-RUN reset and saturation.
module tb_clkfx_lock_sequencer;

`ifdef CLKFX_LOCK_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n1 = 1'b0, locked1 = 1'b1;
  logic       rst_n2 = 1'b0, locked2 = 1'b1;
  logic       srn1, lok1, ce1, srn2, lok2, ce2;
  logic [2:0] ph1, ph2;
  logic [1:0] st1, st2;
  logic [7:0] rc1, rc2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clkfx_lock_sequencer #(.DIV(5), .STABLE_CYCLES(64)) dut1 (
    .clk(clk), .rst_n(rst_n1), .locked_in(locked1),
    .sys_rst_n(srn1), .lock_ok(lok1), .ce_div(ce1),
    .phase(ph1), .state(st1), .relock_count(rc1)
  );

  clkfx_lock_sequencer #(.DIV(5), .STABLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .locked_in(locked2),
    .sys_rst_n(srn2), .lock_ok(lok2), .ce_div(ce2),
    .phase(ph2), .state(st2), .relock_count(rc2)
  );

  typedef struct {
    logic       rst_n;
    logic       lk_in;
    int         n;
    logic [1:0] st;
    logic       srn;
    logic       ce;
    logic [2:0] ph;
    logic       chk_ph;
    logic [7:0] rc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic l, int n, logic [1:0] st, logic srn,
                              logic ce, logic [2:0] ph, logic cp, logic [7:0] rc);
    vec_t v;
    v.rst_n = r; v.lk_in = l; v.n = n; v.st = st; v.srn = srn;
    v.ce = ce; v.ph = ph; v.chk_ph = cp; v.rc = rc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n1  = tbl[i].rst_n;
      locked1 = tbl[i].lk_in;
      repeat (tbl[i].n) step();
      chk($sformatf("v%0d.state", i), st1, tbl[i].st);
      chk($sformatf("v%0d.sys_rst_n", i), srn1, tbl[i].srn);
      chk($sformatf("v%0d.lock_ok", i), lok1, tbl[i].srn);
      chk($sformatf("v%0d.ce_div", i), ce1, tbl[i].ce);
      if (tbl[i].chk_ph) chk($sformatf("v%0d.phase", i), ph1, tbl[i].ph);
      chk($sformatf("v%0d.relock", i), rc1, tbl[i].rc);
      $display("vec %0d: rst_n=%0b locked=%0b edges=%0d -> state=%0d srn=%0b ce=%0b ph=%0d rc=%0d",
               i, tbl[i].rst_n, tbl[i].lk_in, tbl[i].n, st1, srn1, ce1, ph1, rc1);
    end
    tbl.delete();
  endtask

  // Count edges after reset release until dut2 reaches RUN (release edge = 1).
  task automatic edges_to_run2(output int k);
    k = 0;
    while (st2 != 2'd2 && k < 40) begin
      step();
      k++;
    end
  endtask

  task automatic relock2();
    int k;
    locked2 = 1'b0;
    repeat (4) step();
    locked2 = 1'b1;
    k = 0;
    while (st2 != 2'd2 && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) chk("relock2_timeout", st2, 2);
  endtask

  initial begin
    int ce_cnt, exp_ph, k, exit_edge;
    logic [7:0] rc_before;

    // Power-up, divider cadence.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0));   // E: first s1 capture
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0));   // E+1
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 0));   // E+2: STABILIZE
    tbl.push_back(mk(1, 1, 63, 1, 0, 0, 0, 1, 0));  // E+65
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 0));   // E+66: RUN
    tbl.push_back(mk(1, 1, 3, 2, 1, 0, 3, 1, 0));
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 4, 1, 0));   // cycle 4
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 4, 2, 1, 1, 4, 1, 0));   // cycle 9
    tbl.push_back(mk(1, 1, 5, 2, 1, 1, 4, 1, 0));   // cycle 14
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 0));
    run_table();

    ce_cnt = 0;
    exp_ph = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      exp_ph = (exp_ph + 1) % 5;
      chk("div.phase", ph1, exp_ph);
      chk("div.ce", ce1, (exp_ph == 4) ? 1 : 0);
      if (ce1) ce_cnt++;
    end
    chk("div.strobes100", ce_cnt, 20);
    $display("divider: %0d strobes in 100 cycles", ce_cnt);

    // Unstable lock: one low cycle mid-window restarts the full window.
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 3, 1, 0, 0, 0, 1, 0));   // STABILIZE, cnt 0
    tbl.push_back(mk(1, 1, 40, 1, 0, 0, 0, 1, 0));  // cnt 40
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, 0));   // L: low captured
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 0));   // L+1: recaptured high
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0));   // L+2: WAIT_LOCK
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 0));   // L+3: STABILIZE again
    tbl.push_back(mk(1, 1, 63, 1, 0, 0, 0, 1, 0));  // L+66
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 0));   // L+67 = 66 after return
    run_table();

    // One-cycle dropout in RUN.
    locked1 = 1'b0; step();
    locked1 = 1'b1; step();
    step();
    if (FILT) begin
      chk("pulse1.state", st1, 2);
      chk("pulse1.srn", srn1, 1);
      chk("pulse1.relock", rc1, 0);
      repeat (3) step();
      chk("pulse1.state_later", st1, 2);
    end else begin
      chk("pulse1.state", st1, 0);
      chk("pulse1.srn", srn1, 0);
      chk("pulse1.relock", rc1, 1);
      repeat (64) step();
      chk("pulse1.relock_window", st1, 1);
      step();
      chk("pulse1.relock_run", st1, 2);
    end
    $display("pulse1: state=%0d relock=%0d", st1, rc1);

    // Three-cycle dropout in RUN: exit edge relative to first low capture.
    rc_before = rc1;
    exit_edge = -1;
    for (int e = 0; e <= 10; e++) begin
      locked1 = (e < 3) ? 1'b0 : 1'b1;
      step();
      if (exit_edge < 0 && st1 != 2'd2) exit_edge = e;
    end
    chk("pulse3.exit_edge", exit_edge, FILT ? 4 : 2);
    chk("pulse3.relock", rc1, rc_before + 8'd1);
    $display("pulse3: exit at L+%0d relock=%0d", exit_edge, rc1);

    // Short-window instance: startup latency, relock counting, mid-RUN reset.
    rst_n2 = 1'b1;
    edges_to_run2(k);
    chk("dut2.startup_edges", k, 5);
    for (int i = 0; i < 7; i++) relock2();
    chk("dut2.relock7", rc2, 7);
    chk("dut2.run_before_rst", st2, 2);
    rst_n2 = 1'b0;
    step();
    chk("rst.state", st2, 0);
    chk("rst.srn", srn2, 0);
    chk("rst.lock_ok", lok2, 0);
    chk("rst.ce", ce2, 0);
    chk("rst.phase", ph2, 0);
    chk("rst.relock", rc2, 0);
    rst_n2 = 1'b1;
    edges_to_run2(k);
    chk("rst.relock_edges", k, 5);
    $display("mid-run reset: relock restored in %0d edges", k);

    // Saturation.
    for (int i = 0; i < 254; i++) relock2();
    chk("sat.254", rc2, 254);
    relock2();
    chk("sat.255", rc2, 255);
    for (int i = 0; i < 45; i++) relock2();
    chk("sat.300", rc2, 255);
    $display("saturation: relock_count=%0d", rc2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clkfx_lock_sequencer.md
# clkfx_lock_sequencer

Reset and clock-enable sequencer on the synthesized CLKFX domain, downstream of the ×5 DCM. It synchronizes the DCM `locked` flag and requires a stable lock window before releasing a domain reset. It then generates a divide-by-DIV clock-enable strobe, which recovers the reference-rate cadence inside the fast domain. Loss of lock re-asserts the domain reset and increments a saturating relock counter.

## Interface
- `DIV`, default 5: ce_div period in clk cycles; legal range 2..8, matching the DCM multiply factor.
- `STABLE_CYCLES`, default 64: number of consecutive synchronized-locked cycles required before release; legal range ≥2.
- `clk` in 1: synthesized DCM CLKFX output; all logic is on this edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `locked_in` in 1: DCM LOCKED, asynchronous to clk.
- `sys_rst_n` out 1: domain reset; high only in state RUN.
- `lock_ok` out 1: same timing as sys_rst_n; intended for an LED or status bit.
- `ce_div` out 1: one-cycle strobe every DIV cycles while in RUN.
- `phase` out 3: divider phase, 0..DIV-1.
- `state` out 2: 0 = WAIT_LOCK, 1 = STABILIZE, 2 = RUN.
- `relock_count` out 8: number of lock losses from RUN; saturates at 255.

## Operation
- Synchronizer: 2-FF chain s1 → s2; `lk` = s2. No other logic samples `locked_in`.
- WAIT_LOCK: cnt = 0. If lk = 1 → STABILIZE with cnt = 0.
- STABILIZE:
  - lk = 0 → WAIT_LOCK, cnt cleared, no counter increment.
  - lk = 1 and cnt == STABLE_CYCLES-1 → RUN with phase = 0.
  - Otherwise cnt++.
  - cnt width is clog2(STABLE_CYCLES).
- RUN:
  - phase advances (phase+1) mod DIV each cycle.
  - Loss condition (see Configuration) → WAIT_LOCK, phase = 0, relock_count = min(relock_count+1, 255).
- Outputs decode combinationally from registered state/phase only:
  - sys_rst_n = lock_ok = (state == RUN).
  - ce_div = (state == RUN) && (phase == DIV-1).
- Outside RUN, phase is held at 0 and ce_div is 0.
- Encoding 3 of `state` is unreachable; if entered, the FSM returns to WAIT_LOCK on the next edge.
- `rst_n` low at an edge, in any state including mid-STABILIZE or mid-RUN:
  - s1 = s2 = 0, state = WAIT_LOCK, cnt = 0, phase = 0, relock_count = 0.
  - All outputs are 0.
  - Reset dominates all other conditions in the same cycle.

## Timing
- Let locked_in go high and first be captured into s1 at edge E:
  - lk = 1 after E+1.
  - STABILIZE entered at E+2.
  - RUN entered at E+2+STABLE_CYCLES; sys_rst_n rises then. Default: E+66.
- First ce_div is the cycle after edge (RUN entry + DIV-1); thereafter exactly every DIV cycles.
- Lock loss, locked_in captured low at edge L:
  - lk = 0 after L+1.
  - WAIT_LOCK and sys_rst_n = 0 at edge L+2.
- A single lk = 0 cycle during STABILIZE restarts the full window.
- relock_count updates on the same edge as the RUN → WAIT_LOCK transition.
- Relock after loss follows the same full STABLE_CYCLES window.

## Configuration
- `CLKFX_LOCK_GLITCH_FILTER_EN`:
  - Defined: RUN exits only after lk = 0 for 3 consecutive cycles, so the transition is at edge L+4. A 2-bit low-run counter clears on any lk = 1. Low pulses of 1–2 cycles are ignored, with no state change and no relock_count increment.
  - Undefined: a single lk = 0 cycle in RUN exits at edge L+2.
  - STABILIZE behaviour is identical in both builds.

## Test plan
- Power-up: hold rst_n = 0 for 4 cycles with locked_in = 1. All outputs stay 0 during reset. Release reset: sys_rst_n rises exactly 2+64 edges after the first s1 capture, and state passes 0 → 1 → 2.
- Divider: in RUN with DIV = 5, ce_div is high on cycles 4, 9, 14 after entry; phase sequence is 0,1,2,3,4,0; over 100 cycles exactly 20 strobes.
- Unstable lock: drop locked_in for 1 cycle at STABILIZE cnt = 40. Required: state returns to WAIT_LOCK, relock_count stays 0, and sys_rst_n rises a full 64+2 cycles after locked_in returns.
- Lock loss:
  - 1-cycle low pulse in RUN. Filter undefined: sys_rst_n falls at L+2 and relock_count = 1. Filter defined: no change.
  - 3-cycle low pulse with filter defined: exit at L+4.
- Saturation: 300 lock-loss/relock sequences (STABLE_CYCLES = 2) → relock_count = 255.
- Reset mid-RUN: assert rst_n = 0 for one edge with relock_count = 7 → all outputs 0 on that edge, then a normal relock sequence follows.
